// File: rtl/ysyx_22040931_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// There is one request channel with valid/ready and one read-response pulse.
interface ysyx_22040931_mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [7:0]        wmask;
  logic              rsp_valid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req_valid, wen, addr, wdata, wmask,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, wen, addr, wdata, wmask,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/ysyx_22040931_mem_stage.sv
// MEM pipeline stage: takes one EX result, runs at most one data-memory access,
// aligns and extends load data, and presents the writeback record through a one-entry register.
module ysyx_22040931_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pc,
  input  logic              in_w_ena,
  input  logic [4:0]        in_w_addr,
  input  logic [XLEN-1:0]   in_w_data,
  input  logic              in_mem_ena,
  input  logic              in_mem_wr,
  input  logic [2:0]        in_memrop,
  input  logic [2:0]        in_memwop,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [XLEN-1:0]   in_mem_data,
  ysyx_22040931_mem_stage_if.master dmem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic              out_w_ena,
  output logic [4:0]        out_w_addr,
  output logic [XLEN-1:0]   out_w_data,
  output logic              out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, next_state;

  logic              accept;
  logic              misaligned;
  logic [1:0]        size;
  logic [7:0]        size_mask;
  logic              store_done;
  logic              load_done;

  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [7:0]        req_wmask;
  logic [2:0]        req_off;
  logic [2:0]        req_rop;
  logic [63:0]       req_pc;
  logic              req_w_ena;
  logic [4:0]        req_w_addr;

  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_ext;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Access size 0=byte 1=half 2=word 3=double; unused op codes fall back to doubleword.
  always_comb begin
    size = 2'd3;
    if (in_mem_wr) begin
      size = (in_memwop > 3'd2) ? 2'd3 : in_memwop[1:0];
    end else begin
      case (in_memrop)
        3'd0, 3'd4: size = 2'd0;
        3'd1, 3'd5: size = 2'd1;
        3'd2, 3'd6: size = 2'd2;
        default:    size = 2'd3;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hFF;
    case (size)
      2'd0: begin misaligned = 1'b0;                 size_mask = 8'h01; end
      2'd1: begin misaligned = in_mem_addr[0];       size_mask = 8'h03; end
      2'd2: begin misaligned = |in_mem_addr[1:0];    size_mask = 8'h0F; end
      default: begin misaligned = |in_mem_addr[2:0]; size_mask = 8'hFF; end
    endcase
  end

  // Load data: move the addressed byte lane to bit 0, then sign- or zero-extend.
  assign lane = dmem.rdata >> {req_off, 3'b000};

  always_comb begin
    load_ext = lane;
    case (req_rop)
      3'd0: load_ext = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'd1: load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'd2: load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'd4: load_ext = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'd5: load_ext = {{(XLEN-16){1'b0}},     lane[15:0]};
      3'd6: load_ext = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    store_done = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: if (accept && in_mem_ena && !misaligned) next_state = REQ;
      REQ: begin
        if (dmem.req_ready) begin
          if (req_wen) begin
            store_done = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.rsp_valid) begin
          load_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured once at accept so they stay stable while REQ waits for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wen    <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wmask  <= '0;
      req_off    <= '0;
      req_rop    <= '0;
      req_pc     <= '0;
      req_w_ena  <= 1'b0;
      req_w_addr <= '0;
    end else if (accept && in_mem_ena && !misaligned) begin
      req_wen    <= in_mem_wr;
      req_addr   <= {in_mem_addr[ADDR_W-1:3], 3'b000};
      req_wdata  <= in_mem_wr ? (in_mem_data << {in_mem_addr[2:0], 3'b000}) : '0;
      req_wmask  <= in_mem_wr ? 8'(size_mask << in_mem_addr[2:0]) : 8'h00;
      req_off    <= in_mem_addr[2:0];
      req_rop    <= in_memrop;
      req_pc     <= in_pc;
      req_w_ena  <= in_w_ena;
      req_w_addr <= in_w_addr;
    end
  end

  assign dmem.req_valid = (state == REQ);
  assign dmem.wen       = req_wen;
  assign dmem.addr      = req_addr;
  assign dmem.wdata     = req_wdata;
  assign dmem.wmask     = req_wmask;

  // Output slot: accept only happens when it is empty or draining, so loads never overwrite a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_w_ena    <= 1'b0;
      out_w_addr   <= '0;
      out_w_data   <= '0;
      out_misalign <= 1'b0;
    end else if (accept && !in_mem_ena) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_w_ena    <= in_w_ena;
      out_w_addr   <= in_w_addr;
      out_w_data   <= in_w_data;
      out_misalign <= 1'b0;
    end else if (accept && misaligned) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_w_ena    <= 1'b0;
      out_w_addr   <= in_w_addr;
      out_w_data   <= in_w_data;
      out_misalign <= 1'b1;
    end else if (store_done) begin
      out_valid    <= 1'b1;
      out_pc       <= req_pc;
      out_w_ena    <= 1'b0;
      out_w_addr   <= req_w_addr;
      out_w_data   <= '0;
      out_misalign <= 1'b0;
    end else if (load_done) begin
      out_valid    <= 1'b1;
      out_pc       <= req_pc;
      out_w_ena    <= req_w_ena;
      out_w_addr   <= req_w_addr;
      out_w_data   <= load_ext;
      out_misalign <= 1'b0;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
